// File: rtl/alu_frame_controller.sv
// Frame sequencer between the UART byte link and a combinational ALU.
// Receives SOF/OP/A/B/CHK frames and answers with RESULT/RCHK, or NAK on a bad checksum.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_rx_done/i_rx_data UART rx strobe (rising edge is the event) and byte
//   i_tx_done           UART tx byte finished (rising edge is the event)
//   i_alu_result        combinational ALU output
//   o_data_one/two      registered ALU operands A/B
//   o_operation         registered ALU opcode
//   o_tx_start          one-cycle tx start pulse
//   o_tx_data           tx byte, held until the matching i_tx_done edge
//   o_busy              high whenever the sequencer is not idle
//   o_frame_err         one-cycle pulse on checksum error or timeout
//
// Optional: define ALU_FRAME_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES clocks without a new byte.

module alu_frame_controller #(
    parameter int              DBIT           = 8,
    parameter int              NB_OP          = 6,
    parameter logic [DBIT-1:0] SOF            = 8'hA5,
    parameter logic [DBIT-1:0] NAK            = 8'h15,
    parameter int              TIMEOUT_CYCLES = 50000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic             i_tx_done,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic [DBIT-1:0]  o_data_one,
    output logic [DBIT-1:0]  o_data_two,
    output logic [NB_OP-1:0] o_operation,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_frame_err
);

    typedef enum logic [3:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_RCHK,
        WAIT_RCHK,
        SEND_NAK,
        WAIT_NAK
    } state_t;

    state_t state, next_state;

    logic rx_prev, tx_prev;
    logic rx_evt, tx_evt;

    logic [DBIT-1:0] op_q, a_q, b_q, result_q;
    logic            err_q;

    logic ld_op, ld_a, ld_b, ld_opnd, ld_res, err;

    // Previous-value registers run through reset so a line held high
    // across reset does not look like a fresh edge afterwards.
    always_ff @(posedge i_clk) begin
        rx_prev <= i_rx_done;
        tx_prev <= i_tx_done;
    end

    assign rx_evt = i_rx_done & ~rx_prev;
    assign tx_evt = i_tx_done & ~tx_prev;

`ifdef ALU_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          in_rx;
    logic          tmo_hit;

    assign in_rx   = (state == GET_OP) || (state == GET_A) ||
                     (state == GET_B)  || (state == GET_CHK);
    // Count reaches TIMEOUT_CYCLES-1 on the last quiet cycle, so the
    // abort edge lands exactly TIMEOUT_CYCLES clocks after the last byte.
    assign tmo_hit = in_rx && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || !in_rx || rx_evt) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_op      = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_opnd    = 1'b0;
        ld_res     = 1'b0;
        err        = 1'b0;
        o_tx_start = 1'b0;
        o_tx_data  = '0;
        case (state)
            IDLE: begin
                if (rx_evt && (i_rx_data == SOF)) next_state = GET_OP;
            end
            GET_OP: begin
                if (rx_evt) begin
                    ld_op      = 1'b1;
                    next_state = GET_A;
                end
            end
            GET_A: begin
                if (rx_evt) begin
                    ld_a       = 1'b1;
                    next_state = GET_B;
                end
            end
            GET_B: begin
                if (rx_evt) begin
                    ld_b       = 1'b1;
                    next_state = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_evt) begin
                    if (i_rx_data == (op_q ^ a_q ^ b_q)) begin
                        ld_opnd    = 1'b1;
                        next_state = EXEC;
                    end else begin
                        err        = 1'b1;
                        next_state = SEND_NAK;
                    end
                end
            end
            EXEC: begin
                ld_res     = 1'b1;
                next_state = SEND_RES;
            end
            SEND_RES: begin
                o_tx_start = 1'b1;
                o_tx_data  = result_q;
                next_state = WAIT_RES;
            end
            WAIT_RES: begin
                o_tx_data = result_q;
                if (tx_evt) next_state = SEND_RCHK;
            end
            SEND_RCHK: begin
                o_tx_start = 1'b1;
                o_tx_data  = result_q ^ op_q;
                next_state = WAIT_RCHK;
            end
            WAIT_RCHK: begin
                o_tx_data = result_q ^ op_q;
                if (tx_evt) next_state = IDLE;
            end
            SEND_NAK: begin
                o_tx_start = 1'b1;
                o_tx_data  = NAK;
                next_state = WAIT_NAK;
            end
            WAIT_NAK: begin
                o_tx_data = NAK;
                if (tx_evt) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
`ifdef ALU_FRAME_TIMEOUT_EN
        // A byte arriving on the limit cycle wins over the timeout.
        if (tmo_hit && !rx_evt) begin
            next_state = IDLE;
            err        = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            o_data_one  <= '0;
            o_data_two  <= '0;
            o_operation <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= err;
            if (ld_op) op_q <= i_rx_data;
            if (ld_a)  a_q  <= i_rx_data;
            if (ld_b)  b_q  <= i_rx_data;
            if (ld_opnd) begin
                o_operation <= op_q[NB_OP-1:0];
                o_data_one  <= a_q;
                o_data_two  <= b_q;
            end
            if (ld_res) result_q <= i_alu_result;
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_alu_frame_controller.sv
// Directed bench for alu_frame_controller: valid frames, bad checksum,
// preamble garbage, reset mid-frame and the inter-byte timeout option.

module tb_alu_frame_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res;
    logic [7:0] data_one, data_two, tx_data;
    logic [5:0] operation;
    logic       tx_start, busy, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    logic [7:0] tx_log[$];

    always #5 clk = ~clk;

    alu_frame_controller #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_tx_done   (tx_done),
        .i_alu_result(alu_res),
        .o_data_one  (data_one),
        .o_data_two  (data_two),
        .o_operation (operation),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    // Stand-in ALU: ADD 0x20, SUB 0x22, anything else 0.
    always_comb begin
        alu_res = 8'h00;
        if (operation == 6'h20) alu_res = data_one + data_two;
        else if (operation == 6'h22) alu_res = data_one - data_two;
    end

    always @(posedge clk) begin
        if (tx_start) tx_log.push_back(tx_data);
        if (frame_err) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] chk);
        send_byte(8'hA5, 1);
        send_byte(op, 1);
        send_byte(a, 1);
        send_byte(b, 1);
        send_byte(chk, 1);
    endtask

    task automatic tx_ack();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Full two-byte response handshake starting at the EXEC cycle.
    task automatic finish_response();
        repeat (2) @(negedge clk);
        tx_ack();
        @(negedge clk);
        tx_ack();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_one, data_two, operation} !== 22'h0) begin
            n_err++;
            $display("FAIL reset_operands: got %h/%h/%h want 0", data_one, data_two, operation);
        end
        n_cmp++;
        if ({tx_start, tx_data, busy, frame_err} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b %h %b %b want 0", tx_start, tx_data, busy, frame_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        tx_log.delete();
        send_frame(8'h20, 8'h64, 8'h0A, 8'h4E);
        n_cmp++;
        if ({data_one, data_two, operation} !== {8'h64, 8'h0A, 6'h20}) begin
            n_err++;
            $display("FAIL add_operands: got %h/%h/%h want 64/0a/20", data_one, data_two, operation);
        end
        n_cmp++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_exec: got start=%b busy=%b want 0/1", tx_start, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h6E) begin
            n_err++;
            $display("FAIL add_res: got start=%b data=%h want 1/6e", tx_start, tx_data);
        end
        @(negedge clk);
        tx_ack();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h4E) begin
            n_err++;
            $display("FAIL add_rchk: got start=%b data=%h want 1/4e", tx_start, tx_data);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_busy_wait: got %b want 1", busy);
        end
        tx_ack();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_busy_end: got %b want 0", busy);
        end
        n_cmp++;
        if (tx_log.size() != 2) begin
            n_err++;
            $display("FAIL add_tx_count: got %0d want 2", tx_log.size());
        end
    endtask

    task automatic test_sub();
        tx_log.delete();
        send_frame(8'h22, 8'h64, 8'h05, 8'h43);
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5F) begin
            n_err++;
            $display("FAIL sub_res: got start=%b data=%h want 1/5f", tx_start, tx_data);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 8'h5F) begin
            n_err++;
            $display("FAIL sub_pulse: got start=%b data=%h want 0/5f", tx_start, tx_data);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx_log.size() != 1) begin
            n_err++;
            $display("FAIL sub_hold: got %0d bytes want 1", tx_log.size());
        end
        tx_ack();
        @(negedge clk);
        tx_ack();
        n_cmp++;
        if (tx_log.size() != 2 || tx_log[tx_log.size()-1] !== 8'h7D || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sub_rchk: got n=%0d busy=%b want n=2 last=7d busy=0", tx_log.size(), busy);
        end
    endtask

    task automatic test_nak();
        int e0;
        tx_log.delete();
        e0 = err_cnt;
        send_frame(8'h20, 8'h64, 8'h0A, 8'h00);
        n_cmp++;
        if (frame_err !== 1'b1 || tx_start !== 1'b1 || tx_data !== 8'h15) begin
            n_err++;
            $display("FAIL nak_send: got err=%b start=%b data=%h want 1/1/15", frame_err, tx_start, tx_data);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL nak_err_pulse: got %b want 0", frame_err);
        end
        n_cmp++;
        if ({data_one, data_two, operation} !== {8'h64, 8'h05, 6'h22}) begin
            n_err++;
            $display("FAIL nak_operands: got %h/%h/%h want 64/05/22", data_one, data_two, operation);
        end
        tx_ack();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx_log.size() != 1 || err_cnt != e0 + 1) begin
            n_err++;
            $display("FAIL nak_end: got busy=%b n=%0d errs=%0d want 0/1/%0d", busy, tx_log.size(), err_cnt - e0, 1);
        end
    endtask

    task automatic test_preamble();
        tx_log.delete();
        send_byte(8'h00, 1);
        send_byte(8'h64, 1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL pre_idle: got busy=%b want 0", busy);
        end
        send_byte(8'hA5, 1);
        send_byte(8'h20, 3);
        send_byte(8'h64, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h4E, 1);
        finish_response();
        n_cmp++;
        if (tx_log.size() != 2) begin
            n_err++;
            $display("FAIL pre_count: got %0d want 2", tx_log.size());
        end else begin
            n_cmp++;
            if (tx_log[0] !== 8'h6E || tx_log[1] !== 8'h4E) begin
                n_err++;
                $display("FAIL pre_bytes: got %h,%h want 6e,4e", tx_log[0], tx_log[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tx_log.delete();
        send_byte(8'hA5, 1);
        send_byte(8'h20, 1);
        @(negedge clk);
        rx_data = 8'h64;
        rx_done = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        rx_data = 8'hA5;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || {data_one, data_two, operation} !== 22'h0) begin
            n_err++;
            $display("FAIL rst_mid_state: got busy=%b ops=%h/%h/%h want 0", busy, data_one, data_two, operation);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx_log.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_edge: got busy=%b n=%0d want 0/0", busy, tx_log.size());
        end
        rx_done = 1'b0;
        send_frame(8'h20, 8'h64, 8'h0A, 8'h4E);
        finish_response();
        n_cmp++;
        if (tx_log.size() != 2 || data_one !== 8'h64 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_next: got n=%0d a=%h busy=%b want 2/64/0", tx_log.size(), data_one, busy);
        end else begin
            n_cmp++;
            if (tx_log[0] !== 8'h6E || tx_log[1] !== 8'h4E) begin
                n_err++;
                $display("FAIL rst_mid_bytes: got %h,%h want 6e,4e", tx_log[0], tx_log[1]);
            end
        end
    endtask

`ifdef ALU_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        tx_log.delete();
        e0 = err_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h20, 1);
        repeat (95) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || err_cnt != e0) begin
            n_err++;
            $display("FAIL tmo_early: got busy=%b errs=%0d want 1/0", busy, err_cnt - e0);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || err_cnt != e0 + 1 || tx_log.size() != 0) begin
            n_err++;
            $display("FAIL tmo_abort: got busy=%b errs=%0d n=%0d want 0/1/0", busy, err_cnt - e0, tx_log.size());
        end
        send_frame(8'h22, 8'h64, 8'h05, 8'h43);
        finish_response();
        n_cmp++;
        if (tx_log.size() != 2 || tx_log[0] !== 8'h5F || tx_log[1] !== 8'h7D) begin
            n_err++;
            $display("FAIL tmo_next: got n=%0d want 5f,7d", tx_log.size());
        end
    endtask
`else
    task automatic test_no_timeout();
        int e0;
        tx_log.delete();
        e0 = err_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h20, 1);
        repeat (200) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || err_cnt != e0) begin
            n_err++;
            $display("FAIL notmo_wait: got busy=%b errs=%0d want 1/0", busy, err_cnt - e0);
        end
        send_byte(8'h64, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h4E, 1);
        finish_response();
        n_cmp++;
        if (tx_log.size() != 2 || tx_log[0] !== 8'h6E || tx_log[1] !== 8'h4E) begin
            n_err++;
            $display("FAIL notmo_resp: got n=%0d want 6e,4e", tx_log.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_nak();
        test_preamble();
        test_reset_mid();
`ifdef ALU_FRAME_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_frame_controller.md
Name: alu_frame_controller

Overview:
- Sequencer between the UART byte link and the combinational ALU.
- Receives framed commands from UART rx: SOF, OP, A, B, CHK.
- Validates the checksum, drives and holds the ALU operands, and captures the result.
- Sends a two-byte response (RESULT, RCHK) through UART tx, or a single NAK byte on a bad frame.

Parameters:
- DBIT, 8, data/byte width.
- NB_OP, 6, ALU operation code width.
- SOF, 8'hA5, start-of-frame byte.
- NAK, 8'h15, byte sent on checksum error.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clocks. Used only with TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  UART rx byte-valid strobe. Level of any length; the rising edge is the event.
- i_rx_data  in  DBIT  received byte, valid at the i_rx_done rising edge.
- i_tx_done  in  1  UART tx finished current byte. Rising edge is the event.
- i_alu_result  in  DBIT  ALU output, combinational from o_data_one/o_data_two/o_operation.
- o_data_one  out  DBIT  ALU operand A, registered.
- o_data_two  out  DBIT  ALU operand B, registered.
- o_operation  out  NB_OP  ALU opcode, registered.
- o_tx_start  out  1  one-cycle pulse starting a tx byte.
- o_tx_data  out  DBIT  byte to transmit. Held stable until the matching i_tx_done edge.
- o_busy  out  1  high in every state except IDLE.
- o_frame_err  out  1  one-cycle pulse on checksum error or timeout.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE.
- Edge detectors:
  - Previous-value registers for i_rx_done and i_tx_done sample their inputs every cycle, including during reset, so a line held high through reset produces no edge.
  - rx_evt = i_rx_done & ~prev; tx_evt likewise.
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_RES, WAIT_RES, SEND_RCHK, WAIT_RCHK, SEND_NAK, WAIT_NAK.
- Receive path:
  - IDLE: on rx_evt with byte == SOF, go to GET_OP. Any other byte is discarded.
  - GET_OP, GET_A, GET_B: each rx_evt stores the byte into a shadow register (op byte is the full DBIT) and advances.
  - GET_CHK: on rx_evt, compare the byte with op_byte ^ a_byte ^ b_byte.
    - Match: load o_operation = op_byte[NB_OP-1:0], o_data_one = a, o_data_two = b; go to EXEC.
    - Mismatch: pulse o_frame_err; go to SEND_NAK. Operand outputs are unchanged.
  - SOF is not special after IDLE. 0xA5 in GET_OP..GET_CHK is ordinary data.
- EXEC: one cycle for the ALU to settle. At its end, capture i_alu_result into a result register; go to SEND_RES.
- Latency: CHK rx_evt at cycle N → operands valid N+1 → o_tx_start pulse with o_tx_data = result at N+2.
- Transmit path:
  - SEND_x: one-cycle o_tx_start, o_tx_data = byte; go to WAIT_x.
  - WAIT_x: hold o_tx_data; on tx_evt advance.
  - Order: RES → RCHK → IDLE, with RCHK = result ^ op_byte.
  - NAK: SEND_NAK/WAIT_NAK send NAK, then IDLE.
- rx_evt in EXEC or any SEND/WAIT state: byte dropped. No buffering.
- tx_evt outside WAIT states: ignored.
- Operand outputs hold their last valid frame until the next valid CHK or reset.
- Reset mid-frame or mid-transmit: return to IDLE next edge; partial frame discarded; o_tx_start not reissued.
- Simultaneous rx_evt and tx_evt in a WAIT state: tx_evt processed, rx_evt dropped.

Optional Feature:
- Macro ALU_FRAME_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in GET_OP..GET_CHK and clears on every rx_evt and on entry from IDLE.
  - On reaching TIMEOUT_CYCLES: pulse o_frame_err, go to IDLE, no NAK sent.
- Undefined: no counter; receive states wait indefinitely.

Test Plan:
- Frame A5,20,64,0A,4E (op ADD 6'h20) → o_data_one=0x64, o_data_two=0x0A, o_operation=0x20 at N+1; tx 0x6E, then after i_tx_done 0x4E; o_busy low after second i_tx_done.
- Frame A5,22,64,05,43 (SUB) → tx 0x5F then 0x7D; o_tx_start exactly one cycle each; no second byte before i_tx_done.
- Frame A5,20,64,0A,00 → o_frame_err pulse, tx 0x15 only; operands keep previous 0x64/0x05/0x22.
- Bytes 00,64 then the valid ADD frame → leading bytes ignored; response 0x6E,0x4E. i_rx_done held high 3 clocks counts as one byte.
- Reset asserted after A5,20,64 and i_rx_done high through reset → IDLE, outputs 0, no spurious byte; next full ADD frame responds correctly.
- With ALU_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A5,20 then idle 100 clocks → o_frame_err pulse, IDLE, no tx; the following valid frame is processed normally.
